drum_iteration_sync: RTL

- Sits downstream of the column array. It collects the drum centre-node amplitude after every finished iteration and delivers it as audio samples to the codec FIFO interface over a valid/ready handshake.
- It also paces the array: it broadcasts the one-cycle iteration_enable pulse only when every column is idle and an audio sample period has elapsed. Simulation speed is therefore locked to the audio rate.

---
 rtl/drum_iteration_sync.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/drum_iteration_sync.sv
// Drum iteration pacer: gates column iterations to the audio sample rate
// and buffers centre-node samples in a small show-ahead FIFO for the codec.
//
// Ports:
//   clk, reset_n      clock, async active-low reset
//   column_done       per-column idle flags (all high = iteration finished)
//   center_node       signed 1.17 centre amplitude, valid while all done
//   iteration_enable  one-cycle start pulse to every column
//   audio_data        FIFO head, {center_node, 14'd0}
//   audio_valid       FIFO not empty
//   audio_ready       codec accepts audio_data this cycle
//   fifo_level        FIFO occupancy
//   overrun_count     samples dropped on a full FIFO (saturating)
//   late_count        ticks arriving while one is already pending (saturating)
module drum_iteration_sync #(
  parameter int NUM_COLUMNS = 30,
  parameter int SAMPLE_DIV  = 1042,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_COLUMNS-1:0]        column_done,
  input  logic [17:0]                   center_node,
  output logic                          iteration_enable,
  output logic [31:0]                   audio_data,
  output logic                          audio_valid,
  input  logic                          audio_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   overrun_count,
  output logic [15:0]                   late_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  typedef enum logic [2:0] {
    WAIT_DONE,
    CAPTURE,
    WAIT_TICK,
    FIRE,
    GUARD
  } state_t;

  state_t        state;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic          tick_pending;
  logic          fire_clr;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] prev_ptr;
  logic          push;
  logic          pop;
  logic          full;
  logic          accept;
  logic          drop;

  assign tick     = (tick_cnt == CW'(SAMPLE_DIV - 1));
  assign fire_clr = (state == FIRE);

  assign push     = (state == CAPTURE);
  assign full     = (fifo_level == LW'(FIFO_DEPTH));
  assign pop      = audio_valid && audio_ready;
  assign accept   = push && (!full || pop);
  assign drop     = push && full && !pop;
  assign prev_ptr = rd_ptr - AW'(1);

  // When empty, the slot behind the read pointer still holds the last
  // popped sample (it can only be rewritten once the FIFO fills), so the
  // output keeps its previous value without a dedicated holding register.
  assign audio_valid = (fifo_level != '0);
  assign audio_data  = audio_valid ? mem[rd_ptr] : mem[prev_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt     <= '0;
      tick_pending <= 1'b0;
      late_count   <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
      if (tick) begin
        tick_pending <= 1'b1;
        if (tick_pending && !fire_clr && late_count != 16'hFFFF)
          late_count <= late_count + 16'd1;
      end else if (fire_clr) begin
        tick_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= WAIT_DONE;
      iteration_enable <= 1'b0;
    end else begin
      unique case (state)
        WAIT_DONE: if (&column_done) state <= CAPTURE;
        CAPTURE:   state <= WAIT_TICK;
        WAIT_TICK: begin
          if (tick_pending || tick) begin
            state            <= FIRE;
            iteration_enable <= 1'b1;
          end
        end
        FIRE: begin
          state            <= GUARD;
          iteration_enable <= 1'b0;
        end
        GUARD:     state <= WAIT_DONE;
        default:   state <= WAIT_DONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_level    <= '0;
      overrun_count <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= {center_node, 14'd0};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (accept && !pop)
        fifo_level <= fifo_level + LW'(1);
      else if (pop && !accept)
        fifo_level <= fifo_level - LW'(1);
      if (drop && overrun_count != 16'hFFFF)
        overrun_count <= overrun_count + 16'd1;
    end
  end

endmodule
